// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith/compare, iterative 1-bit/cycle shifts.
// Define SEQ_ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module seq_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal_op
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLL  = 4'b0011,
      OP_SRL  = 4'b0100,
      OP_SRA  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_SLTU = 4'b1000,
      OP_XOR  = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
`ifndef SEQ_ALU_FAST_SHIFT_EN
      S_SHIFT = 2'd1,
`endif
      S_DONE  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            illegal_q, illegal_d;
   logic            accept;
   logic            in_is_shift;

`ifndef SEQ_ALU_FAST_SHIFT_EN
   logic [SHW-1:0]  count_q, count_d;
   logic [3:0]      op_q, op_d;
`endif

   // Everything except the iterative shifts resolves in one cycle.
   function automatic logic [XLEN-1:0] alu_comb(input logic [3:0]      op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
`ifdef SEQ_ALU_FAST_SHIFT_EN
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
`endif
      alu_comb = '0;
      case (op)
         OP_AND:  alu_comb = a & b;
         OP_OR:   alu_comb = a | b;
         OP_XOR:  alu_comb = a ^ b;
         OP_ADD:  alu_comb = a + b;
         OP_SUB:  alu_comb = a - b;
         OP_SLT:  alu_comb = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_comb = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef SEQ_ALU_FAST_SHIFT_EN
         OP_SLL:  alu_comb = a << sh;
         OP_SRL:  alu_comb = a >> sh;
         OP_SRA:  alu_comb = XLEN'($signed(a) >>> sh);
`endif
         default: alu_comb = '0;
      endcase
   endfunction

`ifndef SEQ_ALU_FAST_SHIFT_EN
   function automatic logic [XLEN-1:0] shift1(input logic [3:0]      op,
                                              input logic [XLEN-1:0] v);
      case (op)
         OP_SLL:  shift1 = {v[XLEN-2:0], 1'b0};
         OP_SRL:  shift1 = {1'b0, v[XLEN-1:1]};
         default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
      endcase
   endfunction
`endif

   assign accept      = in_valid && in_ready;
   assign in_is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                        (alu_control == OP_SRA);

   // NOTE: sequential state uses non-blocking assignments only; the reset branch is synchronous, so it lives inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
         count_q   <= '0;
         op_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
`ifndef SEQ_ALU_FAST_SHIFT_EN
         count_q   <= count_d;
         op_q      <= op_d;
`endif
      end
   end

   // NOTE: every combinational output gets a default at the top of the block so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_DONE;
`ifndef SEQ_ALU_FAST_SHIFT_EN
               if (in_is_shift && (operand_b[SHW-1:0] != '0)) state_d = S_SHIFT;
`endif
            end
         end
`ifndef SEQ_ALU_FAST_SHIFT_EN
         S_SHIFT: if (count_q == SHW'(1)) state_d = S_DONE;
`endif
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      count_d   = count_q;
      op_d      = op_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               illegal_d = (alu_control > OP_XOR);
               result_d  = alu_comb(alu_control, operand_a, operand_b);
`ifndef SEQ_ALU_FAST_SHIFT_EN
               op_d = alu_control;
               if (in_is_shift) begin
                  result_d = operand_a;
                  count_d  = operand_b[SHW-1:0];
               end
`endif
               zero_d = (result_d == '0);
            end
         end
`ifndef SEQ_ALU_FAST_SHIFT_EN
         S_SHIFT: begin
            result_d = shift1(op_q, result_q);
            count_d  = count_q - SHW'(1);
            zero_d   = (result_d == '0);
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE) && rst_n;
      out_valid = (state_q == S_DONE);
   end

   assign result     = result_q;
   assign zero       = zero_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (default iterative-shift build).
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal_op;

   int errors = 0;
   int checks = 0;

   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SLL = 4'b0011,
                          C_SRL = 4'b0100, C_SRA = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111,
                          C_SLTU = 4'b1000, C_XOR = 4'b1001;

   seq_alu #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, measure latency, check outputs, then drain with a one-cycle out_ready pulse.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_ill, input int exp_lat);
      int lat;
      bit busy_ok;
      @(negedge clk);
      alu_control = op;
      operand_a   = a;
      operand_b   = b;
      in_valid    = 1'b1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      alu_control = 4'b1111;
      operand_a   = $urandom;
      operand_b   = $urandom;
      lat     = 0;
      busy_ok = 1'b1;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (in_ready) busy_ok = 1'b0;
         if (out_valid) break;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, 32'(busy_ok), 32'd1);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
      check({tag, "_illegal"}, 32'(illegal_op), 32'(exp_ill));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      alu_control = '0;
      operand_a   = '0;
      operand_b   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Single-cycle ops
      do_op("sub_neg",  C_SUB,  32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0, 1);
      do_op("sub_zero", C_SUB,  32'h1234,     32'h1234,     32'h0,         1'b1, 1'b0, 1);
      do_op("slt",      C_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1,         1'b0, 1'b0, 1);
      do_op("sltu",     C_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b1, 1'b0, 1);
      do_op("add_wrap", C_ADD,  32'hFFFF_FFFF, 32'd1,       32'd0,         1'b1, 1'b0, 1);
      do_op("or",       C_OR,   32'hF0F0,     32'hFF00,     32'hFFF0,      1'b0, 1'b0, 1);

      // Iterative shifts
      do_op("sra",      C_SRA,  32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, 1'b0, 5);
      do_op("srl",      C_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000, 1'b0, 1'b0, 5);
      do_op("sll31",    C_SLL,  32'd1,        32'd31,       32'h8000_0000, 1'b0, 1'b0, 32);
      do_op("sll0",     C_SLL,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
      do_op("sra_pos",  C_SRA,  32'h4000_0000, 32'd2,       32'h1000_0000, 1'b0, 1'b0, 3);
      do_op("sll_out",  C_SLL,  32'h8000_0000, 32'd1,       32'h0,         1'b1, 1'b0, 2);

      // Illegal code, then a legal op clears the flag
      do_op("illegal",  4'b1100, 32'h1234_5678, 32'h9ABC,   32'h0,         1'b1, 1'b1, 1);
      do_op("and",      C_AND,  32'hF0F0,     32'hFF00,     32'hF000,      1'b0, 1'b0, 1);

      // Backpressure: ADD 3+4 held in DONE for 3 cycles
      @(negedge clk);
      alu_control = C_ADD;
      operand_a   = 32'd3;
      operand_b   = 32'd4;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      operand_a   = 32'd100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_result", result, 32'd7);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_drain_valid", 32'(out_valid), 32'd0);
      check("bp_drain_ready", 32'(in_ready), 32'd1);

      // Reset in the middle of SLL by 20
      @(negedge clk);
      alu_control = C_SLL;
      operand_a   = 32'd1;
      operand_b   = 32'd20;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_valid_low", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_zero", 32'(zero), 32'd0);
      check("mid_rst_illegal", 32'(illegal_op), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_in_ready", 32'(in_ready), 32'd1);
      begin
         bit stayed_low;
         stayed_low = 1'b1;
         repeat (25) begin
            @(negedge clk);
            if (out_valid) stayed_low = 1'b0;
         end
         check("mid_discarded", 32'(stayed_low), 32'd1);
      end
      do_op("xor", C_XOR, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and returns a registered 32-bit result over a valid/ready handshake. Single-cycle logic/arithmetic/compare ops; shifts are iterative, one bit per cycle, to save area. Sits between the decode/operand-fetch stage and writeback/branch logic of the multi-cycle core.

Parameters:
XLEN, 32, datapath width; shift amount is operand_b[$clog2(XLEN)-1:0]

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept request
alu_control  input  4  operation code (encoding below)
operand_a  input  XLEN  first operand
operand_b  input  XLEN  second operand / shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  registered result
zero  output  1  result == 0, valid with out_valid
illegal_op  output  1  captured code was not a defined op, valid with out_valid

Behaviour:
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 SRA, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 XOR; 1010-1111 illegal.
- States: IDLE, SHIFT, DONE.
- in_ready = 1 only in IDLE and only when rst_n high; 0 in SHIFT and DONE (no accept-while-draining).
- Accept = in_valid && in_ready. Code, operands, and shift count are captured on accept; later input changes are ignored.
- IDLE, accept, non-shift op: result computed and registered on the accept edge; -> DONE; out_valid high the next cycle (latency 1).
- IDLE, accept, shift op: working register <= operand_a, count <= shamt. If shamt == 0 -> DONE directly (latency 1), else -> SHIFT.
- SHIFT: each cycle shift the working register 1 bit (SLL: zero fill at LSB; SRL: zero fill at MSB; SRA: replicate MSB) and decrement count. When count reaches 0 that same cycle -> DONE. Total latency from accept edge to out_valid = shamt + 1 cycles (max XLEN).
- DONE: out_valid = 1; result, zero, and illegal_op are held stable until out_valid && out_ready; then -> IDLE. out_valid deasserts the following cycle.
- Arithmetic: ADD/SUB are modulo 2^XLEN with no carry/overflow output. SLT is signed and SLTU is unsigned compare; both give result 1 or 0 zero-extended.
- Illegal code: result = 0, zero = 1, illegal_op = 1, latency 1. It never hangs.
- zero is computed from the final result, including after a shift.
- Reset (rst_n low at a clock edge, in any state including mid-SHIFT or DONE with a pending result): state = IDLE; out_valid, result, zero, illegal_op, and count = 0; the in-flight op is discarded. in_ready = 0 while rst_n is low, 1 on the first cycle after release.

Optional Feature:
SEQ_ALU_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter. Every op has latency 1, the SHIFT state and counter are not built, and results are identical.
- Undefined: iterative shifting as specified above.

Test Plan:
- SUB a=5, b=7 -> result 0xFFFFFFFE, zero=0, out_valid exactly 1 cycle after accept. SUB a=b=0x1234 -> result 0, zero=1.
- SRA a=0x80000000, b=4 -> result 0xF8000000, out_valid 5 cycles after accept, in_ready low throughout. SRL same operands -> 0x08000000. SLL a=1, b=31 -> 0x80000000 after 32 cycles. SLL b=0 -> result a, latency 1.
- SLT a=0xFFFFFFFF, b=1 -> result 1. SLTU same operands -> result 0.
- Backpressure: ADD 3+4 with out_ready held low 3 cycles -> result 7 and out_valid stable throughout, in_ready 0; out_ready pulse -> next cycle out_valid 0, in_ready 1.
- Illegal code 1100 -> result 0, zero 1, illegal_op 1, latency 1. The next legal op clears illegal_op.
- Assert rst_n low for 1 cycle mid-SHIFT (SLL b=20, after 5 cycles) -> out_valid never rises for that op, all outputs 0, in_ready 1 the cycle after release. A new XOR 0xF0F0^0x0FF0 -> 0xFF00.
